// File: rtl/zmodem_pkg.sv
// Shared Z-modem datapath definitions: serializer FSM encoding and lane-count sizing.
package zmodem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_RUN_FULL = 2'd2
  } ser_state_e;

  // Width of a counter that can hold 0..lanes inclusive.
  function automatic int unsigned lane_cnt_w(input int unsigned lanes);
    return $clog2(lanes + 1);
  endfunction

endpackage

// File: rtl/blk_lane_shifter.sv
// ACTIVE slot: holds one block, presents its next lane and shifts it out on each handshake.
module blk_lane_shifter
  import zmodem_pkg::*;
#(
  parameter int unsigned  BLOCK_BYTES = 16,
  parameter int unsigned  LANE_W      = 8,
  parameter bit           MSB_FIRST   = 1'b1,
  localparam int unsigned DATA_W      = BLOCK_BYTES * LANE_W,
  localparam int unsigned CNT_W       = lane_cnt_w(BLOCK_BYTES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CNT_W-1:0]  nbytes_i,
  input  logic              last_i,
  input  logic              adv_i,
  output logic              valid_o,
  output logic [LANE_W-1:0] lane_o,
  output logic              lane_last_o,
  output logic              final_o
);

  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              valid_q, tlast_q;

  // A load always wins; the top only loads when the slot is empty or its final lane leaves.
  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    last_d = last_q;
    if (load_i) begin
      data_d = data_i;
      cnt_d  = (nbytes_i == '0 || nbytes_i > CNT_W'(BLOCK_BYTES)) ? CNT_W'(BLOCK_BYTES) : nbytes_i;
      last_d = last_i;
    end else if (adv_i && cnt_q != '0) begin
      data_d = MSB_FIRST ? (data_q << LANE_W) : (data_q >> LANE_W);
      cnt_d  = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      tlast_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      valid_q <= (cnt_d != '0);
      tlast_q <= last_d && (cnt_d == CNT_W'(1));
    end
  end

  assign valid_o     = valid_q;
  assign lane_o      = MSB_FIRST ? data_q[DATA_W-1 -: LANE_W] : data_q[LANE_W-1:0];
  assign lane_last_o = tlast_q;
  assign final_o     = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/block_serializer.sv
// Block-to-lane serializer: PENDING slot plus FSM in front of the ACTIVE lane shifter.
module block_serializer
  import zmodem_pkg::*;
#(
  parameter int unsigned  BLOCK_BYTES = 16,
  parameter int unsigned  LANE_W      = 8,
  parameter bit           MSB_FIRST   = 1'b1,
  localparam int unsigned DATA_W      = BLOCK_BYTES * LANE_W,
  localparam int unsigned CNT_W       = lane_cnt_w(BLOCK_BYTES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_block_data,
  input  logic [CNT_W-1:0]  s_block_nbytes,
  input  logic              s_block_last,
  input  logic              s_block_valid,
  output logic              s_block_ready,
  output logic [LANE_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              idle
);

  ser_state_e        state_q, state_d;
  logic [DATA_W-1:0] pend_data_q, pend_data_d;
  logic [CNT_W-1:0]  pend_nb_q, pend_nb_d;
  logic              pend_last_q, pend_last_d;
  logic              ready_q, ready_d;
  logic              idle_q, idle_d;

  logic              accept, lane_hs, final_hs, act_final;
  logic              load;
  logic [DATA_W-1:0] ld_data;
  logic [CNT_W-1:0]  ld_nb;
  logic              ld_last;

  assign accept   = s_block_valid && ready_q;
  assign lane_hs  = m_axis_tvalid && m_axis_tready;
  assign final_hs = lane_hs && act_final;

  always_comb begin
    state_d     = state_q;
    pend_data_d = pend_data_q;
    pend_nb_d   = pend_nb_q;
    pend_last_d = pend_last_q;
    load        = 1'b0;
    ld_data     = s_block_data;
    ld_nb       = s_block_nbytes;
    ld_last     = s_block_last;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          load    = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Accept coinciding with the final lane refills ACTIVE directly, so no bubble.
        if (accept && final_hs) begin
          load = 1'b1;
        end else if (accept) begin
          pend_data_d = s_block_data;
          pend_nb_d   = s_block_nbytes;
          pend_last_d = s_block_last;
          state_d     = ST_RUN_FULL;
        end else if (final_hs) begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN_FULL: begin
        if (final_hs) begin
          load    = 1'b1;
          ld_data = pend_data_q;
          ld_nb   = pend_nb_q;
          ld_last = pend_last_q;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d != ST_RUN_FULL);
    idle_d  = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      pend_data_q <= '0;
      pend_nb_q   <= '0;
      pend_last_q <= 1'b0;
      ready_q     <= 1'b0;
      idle_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      pend_data_q <= pend_data_d;
      pend_nb_q   <= pend_nb_d;
      pend_last_q <= pend_last_d;
      ready_q     <= ready_d;
      idle_q      <= idle_d;
    end
  end

  blk_lane_shifter #(
    .BLOCK_BYTES (BLOCK_BYTES),
    .LANE_W      (LANE_W),
    .MSB_FIRST   (MSB_FIRST)
  ) u_active (
    .clk         (clk),
    .rst_n       (reset),
    .load_i      (load),
    .data_i      (ld_data),
    .nbytes_i    (ld_nb),
    .last_i      (ld_last),
    .adv_i       (lane_hs),
    .valid_o     (m_axis_tvalid),
    .lane_o      (m_axis_tdata),
    .lane_last_o (m_axis_tlast),
    .final_o     (act_final)
  );

  assign s_block_ready = ready_q;
  assign idle          = idle_q;

endmodule

// File: tb/tb_block_serializer.sv
// Randomized bench for block_serializer: three parameter sets, each against a lane-queue model.
module tb_block_serializer;

  int   checks = 0;
  int   errors = 0;
  logic clk    = 1'b0;
  bit   done [3];

  always #5 clk = ~clk;

  function automatic int unsigned lane_cnt(int unsigned nb, int unsigned bb);
    return (nb == 0 || nb > bb) ? bb : nb;
  endfunction

  // i-th lane in send order of a block of bb lanes, lw bits each.
  function automatic logic [15:0] lane_at(logic [255:0] data, int unsigned i, int unsigned bb,
                                          int unsigned lw, bit msb);
    int unsigned  idx = msb ? bb - 1 - i : i;
    logic [255:0] m   = (256'(1) << lw) - 256'(1);
    return 16'((data >> (idx * lw)) & m);
  endfunction

  task automatic chk(string name, longint unsigned act, longint unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int unsigned BB  = (g == 1) ? 4 : 16;
    localparam int unsigned LW  = (g == 1) ? 16 : 8;
    localparam bit          MSB = (g == 0);
    localparam int unsigned NW  = $clog2(BB + 1);
    localparam int unsigned DW  = BB * LW;

    typedef struct {
      logic [LW-1:0] d;
      bit            last;
      bit            eob;
    } lane_t;

    logic          reset   = 1'b0;
    logic [DW-1:0] s_data  = '0;
    logic [NW-1:0] s_nb    = '0;
    logic          s_last  = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [LW-1:0] tdata;
    logic          tvalid;
    logic          tready  = 1'b1;
    logic          tlast;
    logic          idle;

    lane_t       mq[$];
    lane_t       ml;
    int          nblk = 0;
    bit          mrdy = 1'b0;
    bit          m_hs, m_acc;
    int unsigned m_n;
    int          tmode = 0;
    int          cyc   = 0;

    block_serializer #(
      .BLOCK_BYTES (BB),
      .LANE_W      (LW),
      .MSB_FIRST   (MSB)
    ) u_dut (
      .clk            (clk),
      .reset          (reset),
      .s_block_data   (s_data),
      .s_block_nbytes (s_nb),
      .s_block_last   (s_last),
      .s_block_valid  (s_valid),
      .s_block_ready  (s_ready),
      .m_axis_tdata   (tdata),
      .m_axis_tvalid  (tvalid),
      .m_axis_tready  (tready),
      .m_axis_tlast   (tlast),
      .idle           (idle)
    );

    // Sink: always ready, 1-0-0 stall pattern, or coin flip.
    initial forever begin
      @(negedge clk);
      cyc++;
      case (tmode)
        0:       tready = 1'b1;
        1:       tready = (cyc % 3 == 0);
        default: tready = 1'($urandom_range(0, 1));
      endcase
    end

    // Model: flat queue of lanes still owed; at most two blocks (ACTIVE + PENDING) held.
    initial forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        mq.delete();
        nblk = 0;
        mrdy = 1'b0;
      end else begin
        m_hs  = (mq.size() != 0) && tready;
        m_acc = s_valid && mrdy;
        if (m_hs) begin
          if (mq[0].eob) nblk--;
          void'(mq.pop_front());
        end
        if (m_acc) begin
          m_n = lane_cnt(int'(s_nb), BB);
          for (int i = 0; i < int'(m_n); i++) begin
            ml.d    = LW'(lane_at(256'(s_data), i, BB, LW, MSB));
            ml.eob  = (i == int'(m_n) - 1);
            ml.last = s_last && ml.eob;
            mq.push_back(ml);
          end
          nblk++;
        end
        mrdy = (nblk < 2);
      end
    end

    initial forever begin
      @(negedge clk);
      if (!reset) begin
        chk($sformatf("g%0d rst tvalid", g), tvalid, 0);
        chk($sformatf("g%0d rst ready", g), s_ready, 0);
        chk($sformatf("g%0d rst tdata", g), tdata, 0);
        chk($sformatf("g%0d rst tlast", g), tlast, 0);
        chk($sformatf("g%0d rst idle", g), idle, 1);
      end else begin
        chk($sformatf("g%0d ready", g), s_ready, mrdy);
        chk($sformatf("g%0d tvalid", g), tvalid, mq.size() != 0);
        chk($sformatf("g%0d idle", g), idle, mq.size() == 0);
        if (mq.size() != 0) begin
          chk($sformatf("g%0d tdata", g), tdata, mq[0].d);
          chk($sformatf("g%0d tlast", g), tlast, mq[0].last);
        end
      end
    end

    // Called at a negedge; returns at the negedge after the block was taken.
    task automatic send(logic [DW-1:0] d, int unsigned nb, bit last);
      int k = 0;
      bit r;
      s_data  = d;
      s_nb    = NW'(nb);
      s_last  = last;
      s_valid = 1'b1;
      forever begin
        r = s_ready;
        @(negedge clk);
        k++;
        if (r) break;
        if (k > 400) begin
          checks++;
          errors++;
          $display("FAIL g%0d accept timeout actual=none required=accept", g);
          break;
        end
      end
      s_valid = 1'b0;
    endtask

    task automatic drain();
      int k = 0;
      tmode = 0;
      while (mq.size() != 0 && k < 3000) begin
        @(negedge clk);
        k++;
      end
      checks++;
      if (mq.size() != 0) begin
        errors++;
        $display("FAIL g%0d drain timeout actual=%0d required=0 lanes", g, mq.size());
      end
      @(negedge clk);
    endtask

    function automatic logic [DW-1:0] rnd_block();
      logic [DW-1:0] d;
      for (int w = 0; w < int'(DW / 32); w++) d[w*32 +: 32] = $urandom;
      return d;
    endfunction

    initial begin
      logic [DW-1:0] d;
      repeat (3) @(negedge clk);
      #2 reset = 1'b1;
      @(negedge clk);

      // Full ramp block 0x00,0x11,... in send order, framed.
      d = '0;
      for (int i = 0; i < int'(BB); i++) d[(MSB ? BB - 1 - i : i) * LW +: LW] = LW'(i * 17);
      send(d, 0, 1'b1);
      repeat (BB + 4) @(negedge clk);

      // Back-to-back pair with the sink always ready.
      send(rnd_block(), 0, 1'b0);
      send(rnd_block(), 0, 1'b1);
      drain();

      // Stall pattern with mixed lengths.
      tmode = 1;
      repeat (3) send(rnd_block(), $urandom_range(0, (1 << NW) - 1), 1'($urandom_range(0, 1)));
      drain();

      // Partial and boundary lengths: 5 (A0..A4), 1, exactly BB, above BB.
      d = '0;
      for (int i = 0; i < int'(BB); i++) d[(MSB ? BB - 1 - i : i) * LW +: LW] = LW'(8'hA0 + i);
      send(d, 5, 1'b1);
      send(rnd_block(), 1, 1'b1);
      send(rnd_block(), BB, 1'b0);
      send(rnd_block(), (1 << NW) - 1, 1'b1);
      drain();

      // Reset mid-block with a block held in PENDING.
      send(rnd_block(), 0, 1'b1);
      send(rnd_block(), 0, 1'b1);
      repeat (5) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk($sformatf("g%0d async rst tvalid", g), tvalid, 0);
      chk($sformatf("g%0d async rst idle", g), idle, 1);
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      repeat (12) @(negedge clk);

      // Random traffic, random sink behaviour, random gaps.
      repeat (60) begin
        tmode = $urandom_range(0, 2);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        send(rnd_block(), $urandom_range(0, (1 << NW) - 1), 1'($urandom_range(0, 1)));
      end
      drain();
      done[g] = 1'b1;
    end
  end

  initial begin
    logic [255:0] d0;
    bit           all_done;
    d0 = 256'(128'h00112233_44556677_8899AABB_CCDDEEFF);
    for (int i = 0; i < 16; i++) chk($sformatf("pin ramp lane %0d", i), lane_at(d0, i, 16, 8, 1), 8'(i * 8'h11));
    d0 = 256'(40'hA4A3A2A1A0);
    for (int i = 0; i < 5; i++) chk($sformatf("pin lsb lane %0d", i), lane_at(d0, i, 16, 8, 0), 8'hA0 + i);
    d0 = 256'(64'h4444_3333_2222_1111);
    chk("pin w16 lsb first", lane_at(d0, 0, 4, 16, 0), 16'h1111);
    chk("pin w16 msb first", lane_at(d0, 0, 4, 16, 1), 16'h4444);
    chk("pin cnt zero", lane_cnt(0, 16), 16);
    chk("pin cnt five", lane_cnt(5, 16), 5);
    chk("pin cnt over", lane_cnt(5, 4), 4);
    chk("pin cnt max", lane_cnt(31, 16), 16);

    all_done = 1'b0;
    for (int k = 0; k < 60000 && !all_done; k++) begin
      @(negedge clk);
      all_done = done[0] && done[1] && done[2];
    end
    checks++;
    if (!all_done) begin
      errors++;
      $display("FAIL run timeout actual=%0d%0d%0d required=111", done[0], done[1], done[2]);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
